rr_arbiter_16: RTL and testbench

- 16-requester round-robin arbiter with grant hold and timeout.
- Directly upstream of the 4-to-16 decoder: grant_idx drives its binary_in, grant_valid drives its enable.
- The decoder output is therefore the one-hot grant vector for the shared resource.
- Arbitration is registered; the grant stays stable until the owner releases, drops its request, or times out.

---
 rtl/rr_arbiter_16.sv | 102 ++++++++++
 tb/tb_rr_arbiter_16.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_16.sv
// 16-requester round-robin arbiter with grant hold and timeout.
// grant_idx/grant_valid feed a 4-to-16 decoder (binary_in/enable), whose output
// is the one-hot grant for the shared resource. All outputs come straight from flops.
// The owner's release pulse is the port "rel"; "release" is a reserved word in SystemVerilog.
module rr_arbiter_16 #(
   parameter int unsigned MAX_HOLD = 255,
   parameter int unsigned CNT_W    = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        arb_en,
   input  logic [15:0] req,
   input  logic        rel,
   output logic [3:0]  grant_idx,
   output logic        grant_valid,
   output logic        timeout
);

   typedef enum logic [0:0] {StIdle, StGrant} state_e;

   localparam logic [CNT_W-1:0] HoldLast = CNT_W'(MAX_HOLD - 1);
   localparam logic [CNT_W-1:0] HoldMax  = CNT_W'(MAX_HOLD);

   state_e           state_q, state_d;
   logic [3:0]       grant_idx_q, grant_idx_d;
   logic [3:0]       ptr_q, ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout_q, timeout_d;
   logic [3:0]       winner;
   logic             win_found;
   logic             owner_drop;
   logic             expired;

   // Rotating-priority search: first set request at or above ptr, wrapping 15 -> 0.
   always_comb begin
      winner    = ptr_q;
      win_found = 1'b0;
      for (int k = 0; k < 16; k++) begin
         if (!win_found && req[ptr_q + 4'(k)]) begin
            winner    = ptr_q + 4'(k);
            win_found = 1'b1;
         end
      end
   end

   // Exit causes for a held grant; release/drop outrank expiry for the timeout flag.
   always_comb begin
      owner_drop = rel | ~req[grant_idx_q];
      expired    = (cnt_q == HoldLast);
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d     = state_q;
      grant_idx_d = grant_idx_q;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      timeout_d   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (arb_en && win_found) begin
               state_d     = StGrant;
               grant_idx_d = winner;
               cnt_d       = '0;
            end
         end
         StGrant: begin
            if (owner_drop || expired) begin
               // Owner drops to lowest priority; grant_idx keeps its last value.
               state_d   = StIdle;
               ptr_d     = grant_idx_q + 4'd1;
               timeout_d = expired & ~owner_drop;
            end else if (cnt_q != HoldMax) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State register with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         grant_idx_q <= 4'd0;
         ptr_q       <= 4'd0;
         cnt_q       <= '0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_idx_q <= grant_idx_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
         timeout_q   <= timeout_d;
      end
   end

   assign grant_idx   = grant_idx_q;
   assign grant_valid = (state_q == StGrant);
   assign timeout     = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_16.sv
// Self-checking bench for rr_arbiter_16: two instances (default hold and a short
// hold of 4) share stimulus and are compared every cycle against a behavioural model.
module tb_rr_arbiter_16;

   logic        clk    = 1'b0;
   logic        rst_n  = 1'b1;
   logic        arb_en = 1'b0;
   logic [15:0] req    = '0;
   logic        rel    = 1'b0;
   logic [3:0]  ga_idx, gb_idx;
   logic        ga_valid, gb_valid, ga_to, gb_to;
   int          n_checks = 0;
   int          n_pass   = 0;

   always #5 clk = ~clk;

   rr_arbiter_16 dut_a (
      .clk         (clk),
      .rst_n       (rst_n),
      .arb_en      (arb_en),
      .req         (req),
      .rel         (rel),
      .grant_idx   (ga_idx),
      .grant_valid (ga_valid),
      .timeout     (ga_to)
   );

   rr_arbiter_16 #(.MAX_HOLD(4), .CNT_W(3)) dut_b (
      .clk         (clk),
      .rst_n       (rst_n),
      .arb_en      (arb_en),
      .req         (req),
      .rel         (rel),
      .grant_idx   (gb_idx),
      .grant_valid (gb_valid),
      .timeout     (gb_to)
   );

   // Model: busy/owner, cycles the grant has been visible, last requester served.
   typedef struct {
      bit busy;
      int owner;
      int age;
      int last;
      bit to;
   } mdl_t;

   mdl_t ma, mb;

   function automatic mdl_t mdl_reset();
      mdl_t m;
      m.busy  = 1'b0;
      m.owner = 0;
      m.age   = 0;
      m.last  = 15;
      m.to    = 1'b0;
      return m;
   endfunction

   function automatic mdl_t mdl_step(mdl_t m, int max_hold, bit en, logic [15:0] r, bit rl);
      mdl_t n = m;
      bit   found = 1'b0;
      bit   drop;
      bit   expire;
      n.to = 1'b0;
      if (!m.busy) begin
         if (en && r != 16'h0) begin
            for (int i = 1; i <= 16; i++) begin
               int c = (m.last + i) % 16;
               if (!found && r[c]) begin
                  found   = 1'b1;
                  n.busy  = 1'b1;
                  n.owner = c;
                  n.age   = 1;
               end
            end
         end
      end else begin
         drop   = rl || !r[m.owner];
         expire = (m.age >= max_hold);
         if (drop || expire) begin
            n.busy = 1'b0;
            n.last = m.owner;
            n.to   = expire && !drop;
         end else begin
            n.age = m.age + 1;
         end
      end
      return n;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   task automatic cmp_all();
      check("a_valid", 32'(ga_valid), 32'(ma.busy));
      check("a_idx",   32'(ga_idx),   32'(ma.owner));
      check("a_to",    32'(ga_to),    32'(ma.to));
      check("b_valid", 32'(gb_valid), 32'(mb.busy));
      check("b_idx",   32'(gb_idx),   32'(mb.owner));
      check("b_to",    32'(gb_to),    32'(mb.to));
   endtask

   // One clock: model advances on the current inputs, outputs compared 1 after the edge.
   task automatic step();
      mdl_t na, nb;
      na = mdl_step(ma, 255, arb_en, req, rel);
      nb = mdl_step(mb, 4, arb_en, req, rel);
      @(posedge clk);
      #1;
      ma = na;
      mb = nb;
      cmp_all();
   endtask

   // Asserts reset away from the edge and checks it took effect before the next edge.
   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      ma = mdl_reset();
      mb = mdl_reset();
      cmp_all();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic wait_grant(input bit use_b, input string tag, input int exp_idx,
                             output int gap);
      gap = 0;
      while (!(use_b ? gb_valid : ga_valid) && gap < 40) begin
         step();
         gap++;
      end
      if (use_b) check(tag, gb_valid ? 32'(gb_idx) : 32'hFFFF_FFFF, 32'(exp_idx));
      else       check(tag, ga_valid ? 32'(ga_idx) : 32'hFFFF_FFFF, 32'(exp_idx));
   endtask

   initial begin
      int gap;
      int n;
      int tos;
      int exp_seq [3] = '{2, 5, 2};

      #1;
      do_reset();

      // No requests: stays idle.
      arb_en = 1'b1;
      req    = 16'h0000;
      for (int i = 0; i < 10; i++) step();

      // Two requesters, release 3 cycles after each grant.
      do_reset();
      req = 16'h0024;
      for (int g = 0; g < 3; g++) begin
         wait_grant(1'b0, "s2_grant", exp_seq[g], gap);
         check("s2_gap", gap, 1);
         step();
         step();
         rel = 1'b1;
         step();
         rel = 1'b0;
      end

      // All requesting: strict rotation with wrap.
      do_reset();
      req = 16'hFFFF;
      for (int g = 0; g < 17; g++) begin
         wait_grant(1'b0, "s3_rot", g % 16, gap);
         step();
         rel = 1'b1;
         step();
         rel = 1'b0;
      end

      // Short-hold instance: expiry after exactly 4 cycles, then re-grant.
      do_reset();
      req = 16'h0100;
      wait_grant(1'b1, "s4_grant", 8, gap);
      n = 0;
      while (gb_valid === 1'b1 && n < 10) begin
         n++;
         step();
      end
      check("s4_len", n, 4);
      check("s4_timeout", 32'(gb_to), 1);
      step();
      check("s4_regrant", gb_valid ? 32'(gb_idx) : 32'hFFFF_FFFF, 8);

      // Owner drops request mid-grant; release in idle ignored.
      do_reset();
      req = 16'h0088;
      wait_grant(1'b0, "s5_grant", 3, gap);
      step();
      req = 16'h0080;
      step();
      check("s5_drop", 32'(ga_valid), 0);
      check("s5_to", 32'(ga_to), 0);
      rel = 1'b1;
      step();
      rel = 1'b0;
      check("s5_next", ga_valid ? 32'(ga_idx) : 32'hFFFF_FFFF, 7);

      // Asynchronous reset mid-grant, then pointer back at 0.
      do_reset();
      req = 16'h0200;
      wait_grant(1'b0, "s6_grant", 9, gap);
      step();
      do_reset();
      req = 16'hFFFF;
      wait_grant(1'b0, "s6_after", 0, gap);
      check("s6_gap", gap, 1);

      // Full-length hold on the default instance.
      do_reset();
      req = 16'h0010;
      tos = 0;
      for (int i = 0; i < 270; i++) begin
         step();
         if (ga_to === 1'b1) tos++;
      end
      check("s7_a_timeouts", tos, 1);

      // Randomized traffic, requests often held to let grants run long.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 9) == 0) req = 16'($urandom) & 16'($urandom);
         arb_en = ($urandom_range(0, 7) != 0);
         rel    = ($urandom_range(0, 11) == 0);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
